// File: rtl/brushless_pwm_if.sv
// Gate-drive bus for brushless_pwm: duty/brake/Hall inputs and the six phase commands.
// The master side is the controller or bench; the slave side is the PWM block.
interface brushless_pwm_if #(
  parameter int PWM_W = 11
);
  logic [PWM_W-1:0] duty;
  logic             brake;
  logic             hallGrn;
  logic             hallYlw;
  logic             hallBlu;
  logic             highGrn;
  logic             lowGrn;
  logic             highYlw;
  logic             lowYlw;
  logic             highBlu;
  logic             lowBlu;
  logic             pwm_synch;
  logic             hall_err;

  modport master (
    output duty, brake, hallGrn, hallYlw, hallBlu,
    input  highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu, pwm_synch, hall_err
  );

  modport slave (
    input  duty, brake, hallGrn, hallYlw, hallBlu,
    output highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu, pwm_synch, hall_err
  );
endinterface

// File: rtl/brushless_pwm.sv
// Three-phase gate commands from PWM, period-aligned Hall commutation and regen brake; ILLEGAL_HALL_BRAKE_EN brakes on illegal Hall codes.
// Counter to outputs 2 clocks, brake to outputs 2 clocks; no backpressure, outputs update every clock.
module brushless_pwm #(
  parameter int PWM_W = 11
) (
  input  logic           clk,
  input  logic           rst,
  brushless_pwm_if.slave bus
);

  typedef enum logic [1:0] {PH_FLT, PH_FWD, PH_REV, PH_BRK} ph_mode_e;

`ifdef ILLEGAL_HALL_BRAKE_EN
  localparam ph_mode_e ILL_MODE = PH_BRK;
`else
  localparam ph_mode_e ILL_MODE = PH_FLT;
`endif

  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic             pwm_sig_q, pwm_sig_d;
  logic             pwm_synch_q, pwm_synch_d;
  logic [2:0]       hall_s1_q, hall_s1_d;
  logic [2:0]       hall_s2_q, hall_s2_d;
  logic [2:0]       rot_q, rot_d;
  logic             hall_err_q, hall_err_d;
  logic             brake_q, brake_d;
  logic [5:0]       drv_q, drv_d;
  logic             cnt_wrap;
  ph_mode_e         mode_g, mode_y, mode_b;

  // Returns {high, low}; no mode can set both.
  function automatic logic [1:0] drive(input ph_mode_e m, input logic p);
    case (m)
      PH_FWD:  drive = {p, ~p};
      PH_REV:  drive = {~p, p};
      PH_BRK:  drive = {1'b0, p};
      default: drive = 2'b00;
    endcase
  endfunction

  always_comb begin
    cnt_wrap    = (cnt_q == {PWM_W{1'b1}});
    cnt_d       = cnt_q + 1'b1;
    duty_d      = cnt_wrap ? bus.duty : duty_q;
    pwm_sig_d   = (cnt_q < duty_q);
    pwm_synch_d = cnt_wrap;
    hall_s1_d   = {bus.hallGrn, bus.hallYlw, bus.hallBlu};
    hall_s2_d   = hall_s1_q;
    rot_d       = cnt_wrap ? hall_s2_q : rot_q;
    hall_err_d  = cnt_wrap ? ((hall_s2_q == 3'b000) || (hall_s2_q == 3'b111)) : hall_err_q;
    brake_d     = bus.brake;

    mode_g = ILL_MODE;
    mode_y = ILL_MODE;
    mode_b = ILL_MODE;
    case (rot_q)
      3'b101: begin mode_g = PH_FWD; mode_y = PH_REV; mode_b = PH_FLT; end
      3'b100: begin mode_g = PH_FWD; mode_y = PH_FLT; mode_b = PH_REV; end
      3'b110: begin mode_g = PH_FLT; mode_y = PH_FWD; mode_b = PH_REV; end
      3'b010: begin mode_g = PH_REV; mode_y = PH_FWD; mode_b = PH_FLT; end
      3'b011: begin mode_g = PH_REV; mode_y = PH_FLT; mode_b = PH_FWD; end
      3'b001: begin mode_g = PH_FLT; mode_y = PH_REV; mode_b = PH_FWD; end
      default: ;
    endcase
    if (brake_q) begin
      mode_g = PH_BRK;
      mode_y = PH_BRK;
      mode_b = PH_BRK;
    end

    drv_d = {drive(mode_g, pwm_sig_q), drive(mode_y, pwm_sig_q), drive(mode_b, pwm_sig_q)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      duty_q      <= '0;
      pwm_sig_q   <= 1'b0;
      pwm_synch_q <= 1'b0;
      hall_s1_q   <= 3'b000;
      hall_s2_q   <= 3'b000;
      rot_q       <= 3'b000;
      hall_err_q  <= 1'b0;
      brake_q     <= 1'b0;
      drv_q       <= 6'b000000;
    end else begin
      cnt_q       <= cnt_d;
      duty_q      <= duty_d;
      pwm_sig_q   <= pwm_sig_d;
      pwm_synch_q <= pwm_synch_d;
      hall_s1_q   <= hall_s1_d;
      hall_s2_q   <= hall_s2_d;
      rot_q       <= rot_d;
      hall_err_q  <= hall_err_d;
      brake_q     <= brake_d;
      drv_q       <= drv_d;
    end
  end

  assign bus.highGrn   = drv_q[5];
  assign bus.lowGrn    = drv_q[4];
  assign bus.highYlw   = drv_q[3];
  assign bus.lowYlw    = drv_q[2];
  assign bus.highBlu   = drv_q[1];
  assign bus.lowBlu    = drv_q[0];
  assign bus.pwm_synch = pwm_synch_q;
  assign bus.hall_err  = hall_err_q;

endmodule

// File: tb/tb_brushless_pwm.sv
// Directed bench for brushless_pwm: per-period high/low pulse counts from a vector table plus brake/duty/reset sequences.
module tb_brushless_pwm;
  localparam int W   = 11;
  localparam int PER = 2048;

  typedef enum int {M_FLT, M_FWD, M_REV, M_BRK} mode_e;

`ifdef ILLEGAL_HALL_BRAKE_EN
  localparam mode_e ILL = M_BRK;
`else
  localparam mode_e ILL = M_FLT;
`endif

  typedef struct {
    logic [2:0] hall;
    int         duty;
    logic       brake;
    mode_e      mg;
    mode_e      my;
    mode_e      mb;
    logic       err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  brushless_pwm_if #(.PWM_W(W)) bus ();
  brushless_pwm #(.PWM_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   n_vec = 0;
  int   n_err = 0;
  int   n_ovl = 0;
  vec_t vt[12];

  function automatic vec_t mk(input logic [2:0] h, input int d, input logic b,
                              input mode_e g, input mode_e y, input mode_e bl, input logic e);
    vec_t v;
    v.hall = h; v.duty = d; v.brake = b; v.mg = g; v.my = y; v.mb = bl; v.err = e;
    return v;
  endfunction

  function automatic integer exp_hi(input mode_e m, input integer d);
    case (m)
      M_FWD:   return d;
      M_REV:   return PER - d;
      default: return 0;
    endcase
  endfunction

  function automatic integer exp_lo(input mode_e m, input integer d);
    case (m)
      M_FWD:   return PER - d;
      M_REV:   return d;
      M_BRK:   return d;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input integer act, input integer exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if ((bus.highGrn & bus.lowGrn) | (bus.highYlw & bus.lowYlw) | (bus.highBlu & bus.lowBlu))
      n_ovl++;
  endtask

  task automatic apply(input logic [2:0] h, input int d, input logic b);
    bus.hallGrn = h[2];
    bus.hallYlw = h[1];
    bus.hallBlu = h[0];
    bus.duty    = d[W-1:0];
    bus.brake   = b;
  endtask

  task automatic wait_synch(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 2 * PER + 8; i++) begin
      tick();
      if (bus.pwm_synch === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check({name, "_synch_timeout"}, 0, 1);
  endtask

  function automatic integer drv_sum();
    return bus.highGrn + bus.lowGrn + bus.highYlw + bus.lowYlw + bus.highBlu + bus.lowBlu;
  endfunction

  // Entered with rst already high: outputs must be 0 at once, then stay 0 until the first boundary.
  task automatic reset_release(input string name);
    integer n, nz;
    #1;
    check({name, "_drv_zero"}, drv_sum(), 0);
    check({name, "_synch_zero"}, bus.pwm_synch, 0);
    check({name, "_err_zero"}, bus.hall_err, 0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    nz = 0;
    for (int i = 0; i < 3 * PER; i++) begin
      tick();
      n++;
      if (drv_sum() != 0) nz++;
      if (bus.pwm_synch === 1'b1) break;
    end
    check({name, "_first_synch_clk"}, n, PER);
    check({name, "_flt_before_boundary"}, nz, 0);
  endtask

  // Window covers cnt=2 .. cnt=1 of the next period: every counter value exactly once.
  task automatic run_row(input vec_t v, input string name);
    integer gh, gl, yh, yl, bh, bl, sc, sp;
    apply(v.hall, v.duty, v.brake);
    wait_synch(name);
    tick();
    tick();
    gh = 0; gl = 0; yh = 0; yl = 0; bh = 0; bl = 0; sc = 0; sp = -1;
    for (int j = 0; j < PER; j++) begin
      if (j > 0) tick();
      gh += bus.highGrn; gl += bus.lowGrn;
      yh += bus.highYlw; yl += bus.lowYlw;
      bh += bus.highBlu; bl += bus.lowBlu;
      if (bus.pwm_synch === 1'b1) begin
        sc++;
        sp = j;
      end
    end
    check({name, "_gh"}, gh, exp_hi(v.mg, v.duty));
    check({name, "_gl"}, gl, exp_lo(v.mg, v.duty));
    check({name, "_yh"}, yh, exp_hi(v.my, v.duty));
    check({name, "_yl"}, yl, exp_lo(v.my, v.duty));
    check({name, "_bh"}, bh, exp_hi(v.mb, v.duty));
    check({name, "_bl"}, bl, exp_lo(v.mb, v.duty));
    check({name, "_synch_cnt"}, sc, 1);
    check({name, "_synch_pos"}, sp, PER - 2);
    check({name, "_hall_err"}, bus.hall_err, v.err);
  endtask

  initial begin
    #(10 * 150000);
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    integer c;
    vt[0]  = mk(3'b101, 512,  1'b0, M_FWD, M_REV, M_FLT, 1'b0);
    vt[1]  = mk(3'b100, 512,  1'b0, M_FWD, M_FLT, M_REV, 1'b0);
    vt[2]  = mk(3'b110, 1024, 1'b0, M_FLT, M_FWD, M_REV, 1'b0);
    vt[3]  = mk(3'b010, 0,    1'b0, M_REV, M_FWD, M_FLT, 1'b0);
    vt[4]  = mk(3'b011, 2047, 1'b0, M_REV, M_FLT, M_FWD, 1'b0);
    vt[5]  = mk(3'b001, 700,  1'b0, M_FLT, M_REV, M_FWD, 1'b0);
    vt[6]  = mk(3'b111, 700,  1'b0, ILL,   ILL,   ILL,   1'b1);
    vt[7]  = mk(3'b010, 700,  1'b0, M_REV, M_FWD, M_FLT, 1'b0);
    vt[8]  = mk(3'b000, 300,  1'b0, ILL,   ILL,   ILL,   1'b1);
    vt[9]  = mk(3'b110, 300,  1'b1, M_BRK, M_BRK, M_BRK, 1'b0);
    vt[10] = mk(3'b111, 300,  1'b1, M_BRK, M_BRK, M_BRK, 1'b1);
    vt[11] = mk(3'b101, 1,    1'b0, M_FWD, M_REV, M_FLT, 1'b0);

    apply(3'b101, 512, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    reset_release("por");

    for (int i = 0; i < 12; i++) run_row(vt[i], $sformatf("row%0d", i));

    // Duty step mid-period: the running period keeps the old width.
    apply(3'b101, 512, 1'b0);
    wait_synch("step");
    tick();
    tick();
    c = 0;
    for (int j = 0; j < 1000; j++) begin
      if (j > 0) tick();
      c += bus.highGrn;
    end
    check("step_first_part", c, 512);
    bus.duty = 11'd1024;
    c = 0;
    for (int j = 0; j < PER - 1000; j++) begin
      tick();
      c += bus.highGrn;
    end
    check("step_rest_old_duty", c, 0);
    c = 0;
    for (int j = 0; j < PER; j++) begin
      tick();
      c += bus.highGrn;
    end
    check("step_new_duty", c, 1024);

    // Brake latency: two clocks from input to outputs, both directions.
    apply(3'b110, 300, 1'b0);
    wait_synch("brk");
    for (int j = 0; j < 10; j++) tick();
    check("brk_pre_yh", bus.highYlw, 1);
    bus.brake = 1'b1;
    tick();
    check("brk_lat1_yh", bus.highYlw, 1);
    tick();
    check("brk_lat2_highs", bus.highGrn + bus.highYlw + bus.highBlu, 0);
    check("brk_lat2_lows", bus.lowGrn + bus.lowYlw + bus.lowBlu, 3);
    bus.brake = 1'b0;
    tick();
    check("unbrk_lat1_yh", bus.highYlw, 0);
    tick();
    check("unbrk_lat2_yh", bus.highYlw, 1);
    check("unbrk_lat2_g", bus.highGrn + bus.lowGrn, 0);
    check("unbrk_lat2_bl", bus.lowBlu, 1);

    // Asynchronous reset while the outputs are driving.
    rst = 1'b1;
    reset_release("midrst");
    run_row(mk(3'b110, 300, 1'b0, M_FLT, M_FWD, M_REV, 1'b0), "post_rst");

    check("no_high_low_overlap", n_ovl, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
